// File: rtl/registro_pkg.sv
// rtl/registro_pkg.sv - shared constants for the switch register peripheral
// Purpose: register-select encodings and debounce counter width.
package registro_pkg;

  localparam int CNT_W = 16;

  localparam logic [1:0] REG_LEVEL = 2'b00;
  localparam logic [1:0] REG_EDGE  = 2'b01;
  localparam logic [1:0] REG_MASK  = 2'b10;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - single-bit synchronizer and debouncer
// Purpose: 2-flop synchronizer followed by a stability counter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   din       - raw asynchronous level
//   stable    - debounced level
module debounce_bit
  import registro_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable
);

  localparam logic [CNT_W-1:0] LAST = DEBOUNCE_CYCLES - CNT_W'(1);

  logic             sync1_q, sync2_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any return to agreement throws the partial count away.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/registro_switches.sv
// rtl/registro_switches.sv - debounced switch register block with edge flags and irq
// Purpose: 8 debounced switches exposed as LEVEL, sticky rising-edge EDGE
//          flags, an interrupt MASK and a level interrupt.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   switches[7:0]        - raw switch levels
//   bitAddress           - chip select
//   regSel[1:0]          - 00 LEVEL, 01 EDGE, 10 MASK, 11 reserved
//   read, write          - access strobes
//   dataWrite[7:0]       - write data
//   dataRead[7:0]        - registered read data
//   irq                  - registered |(EDGE & MASK)
module registro_switches
  import registro_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] switches,
  input  logic       bitAddress,
  input  logic [1:0] regSel,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] dataWrite,
  output logic [7:0] dataRead,
  output logic       irq
);

  logic [7:0] level;
  logic [7:0] level_prev_q, level_prev_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] data_read_q, data_read_d;
  logic       irq_q, irq_d;
  logic [7:0] rise;
  logic       rd_acc, wr_acc;

  for (genvar i = 0; i < 8; i++) begin : g_deb
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .din    (switches[i]),
      .stable (level[i])
    );
  end

  assign rd_acc = bitAddress & read;
  assign wr_acc = bitAddress & write;
  // level_prev resets to 0 together with level, so reset itself never looks like a rise.
  assign rise   = level & ~level_prev_q;

  always_comb begin
    level_prev_d = level;
    mask_d       = mask_q;
    data_read_d  = data_read_q;
    edge_d       = edge_q;

    if (rd_acc) begin
      case (regSel)
        REG_LEVEL: data_read_d = level;
        REG_EDGE:  data_read_d = edge_q;
        REG_MASK:  data_read_d = mask_q;
        default:   data_read_d = 8'h00;
      endcase
    end

    // Clear only what the read returned; a rise in the same cycle survives.
    if (rd_acc && regSel == REG_EDGE) begin
      edge_d = 8'h00;
    end
    edge_d = edge_d | rise;

    if (wr_acc && regSel == REG_MASK) begin
      mask_d = dataWrite;
    end

    irq_d = |(edge_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= 8'h00;
      edge_q       <= 8'h00;
      mask_q       <= 8'h00;
      data_read_q  <= 8'h00;
      irq_q        <= 1'b0;
    end else begin
      level_prev_q <= level_prev_d;
      edge_q       <= edge_d;
      mask_q       <= mask_d;
      data_read_q  <= data_read_d;
      irq_q        <= irq_d;
    end
  end

  assign dataRead = data_read_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_registro_switches.sv
// tb/tb_registro_switches.sv - self-checking bench for registro_switches
module tb_registro_switches;
  import registro_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] switches;
  logic       bitAddress;
  logic [1:0] regSel;
  logic       read;
  logic       write;
  logic [7:0] dataWrite;
  logic [7:0] dataRead;
  logic       irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  registro_switches #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk        (clk),
    .rst        (rst),
    .switches   (switches),
    .bitAddress (bitAddress),
    .regSel     (regSel),
    .read       (read),
    .write      (write),
    .dataWrite  (dataWrite),
    .dataRead   (dataRead),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus cycle; when rd_en is set the expected read data goes on the
  // scoreboard and is compared once dataRead has loaded.
  task automatic acc(input string tag, input logic [1:0] sel, input logic rd_en,
                     input logic wr_en, input logic [7:0] wdata, input logic [7:0] exp);
    bitAddress = 1'b1;
    regSel     = sel;
    read       = rd_en;
    write      = wr_en;
    dataWrite  = wdata;
    if (rd_en) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    tick(1);
    bitAddress = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    if (rd_en) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
        chk(tag_q.pop_front(), dataRead, exp_q.pop_front());
      end
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    acc(tag, sel, 1'b1, 1'b0, 8'h00, exp);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    acc("wr", sel, 1'b0, 1'b1, data, 8'h00);
  endtask

  initial begin
    rst = 1'b1; switches = 8'h00; bitAddress = 1'b0; regSel = 2'b00;
    read = 1'b0; write = 1'b0; dataWrite = 8'h00;
    tick(3);
    rst = 1'b0;
    chk("rst_data", dataRead, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    rd("rst_level", REG_LEVEL, 8'h00);
    rd("rst_edge", REG_EDGE, 8'h00);
    rd("rst_mask", REG_MASK, 8'h00);
    rd("rst_resv", 2'b11, 8'h00);

    // clean step on bit0
    switches = 8'h01;
    tick(2);
    rd("step_early", REG_LEVEL, 8'h00);
    tick(6);
    rd("step_level", REG_LEVEL, 8'h01);
    tick(2);
    chk("irq_nomask", {7'b0, irq}, 8'h00);

    // mask bit2 only, edge bit0 must not interrupt; non-MASK writes ignored
    wr(REG_MASK, 8'h04);
    wr(REG_LEVEL, 8'hAA);
    wr(2'b11, 8'h55);
    tick(2);
    chk("irq_masked", {7'b0, irq}, 8'h00);
    rd("mask_val", REG_MASK, 8'h04);
    rd("resv_after_wr", 2'b11, 8'h00);

    // 3-cycle glitch on bit3 is rejected
    switches = 8'h09;
    tick(3);
    switches = 8'h01;
    tick(10);
    rd("glitch_level", REG_LEVEL, 8'h01);

    // edge on bit2 raises irq; EDGE read clears it
    switches = 8'h05;
    tick(10);
    chk("irq_set", {7'b0, irq}, 8'h01);
    rd("level_05", REG_LEVEL, 8'h05);
    rd("edge_05", REG_EDGE, 8'h05);
    chk("irq_hold", {7'b0, irq}, 8'h01);
    tick(1);
    chk("irq_clr", {7'b0, irq}, 8'h00);
    rd("edge_cleared", REG_EDGE, 8'h00);

    // simultaneous read and write of MASK returns the old value
    acc("rw_mask_old", REG_MASK, 1'b1, 1'b1, 8'hF0, 8'h04);
    rd("rw_mask_new", REG_MASK, 8'hF0);

    // edge on bit1 lands in the same cycle as an EDGE read
    switches = 8'h15;
    tick(10);
    switches = 8'h17;
    tick(6);
    rd("coinc_old", REG_EDGE, 8'h10);
    rd("coinc_kept", REG_EDGE, 8'h02);

    // reset mid-debounce with all switches high
    switches = 8'hFF;
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("mid_rst_data", dataRead, 8'h00);
    chk("mid_rst_irq", {7'b0, irq}, 8'h00);
    rst = 1'b0;
    rd("post_rst_level", REG_LEVEL, 8'h00);
    rd("post_rst_mask", REG_MASK, 8'h00);
    rd("post_rst_edge", REG_EDGE, 8'h00);
    rd("post_rst_early", REG_LEVEL, 8'h00);
    tick(4);
    rd("post_rst_level_ff", REG_LEVEL, 8'hFF);
    rd("post_rst_edge_ff", REG_EDGE, 8'hFF);

    chk("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
